fb_fill_master: RTL and testbench

FB_FILL_MASTER -- requirements
Module: fb_fill_master

---
 rtl/fb_fill_master_if.sv | 28 ++
 rtl/fb_fill_master.sv | 140 ++++++++++++++
 tb/tb_fb_fill_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_fill_master_if.sv
// Avalon-MM write-only bus between the fill master and the framebuffer slave.
// The master drives address/data/strobes; the slave answers with waitrequest.
interface fb_fill_master_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic              chipselect;
  logic              waitrequest;

  modport master (
    output address,
    output writedata,
    output write,
    output chipselect,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  writedata,
    input  write,
    input  chipselect,
    output waitrequest
  );
endinterface

// File: rtl/fb_fill_master.sv
// Framebuffer fill master: writes word_count copies of a pattern to
// consecutive word addresses over Avalon-MM, one word per clock when the
// slave does not stall.
// Optional macro FB_FILL_PATTERN_INC_EN: when defined, each word carries
// fill_data plus its index in the fill instead of the constant fill_data.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; words_written holds the last fill's count
// S_WRITE | issuing writes; down-counter tracks words still to be accepted
// S_DONE  | one-cycle completion (normal or abort), done=1
module fb_fill_master #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written,
  fb_fill_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Largest fill is one full pass over the address space.
  localparam logic [63:0] MAX_WORDS = 64'd1 << ADDR_W;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_write;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_words;
  logic [CNT_W-1:0]  r_remaining;

  logic [63:0]       w_cnt_ext;
  logic [CNT_W-1:0]  w_cnt_clamped;
  logic              w_accept;
  logic              w_last;

  // Clamp requested length so a fill never revisits an address.
  always_comb begin
    w_cnt_ext     = 64'(word_count);
    w_cnt_clamped = word_count;
    if (w_cnt_ext > MAX_WORDS) begin
      w_cnt_clamped = MAX_WORDS[CNT_W-1:0];
    end
  end

  assign w_accept = r_write & ~bus.waitrequest;
  assign w_last   = (r_remaining == CNT_W'(1));

  // Fill sequencer: all bus and status outputs come straight from these flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_words     <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr      <= base_addr;
            r_data      <= fill_data;
            r_words     <= '0;
            r_remaining <= w_cnt_clamped;
            r_busy      <= 1'b1;
            if (word_count == '0) begin
              r_write <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_write <= 1'b1;
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          // A stalled word leaves address/data/strobe untouched.
          if (w_accept) begin
            r_words     <= r_words + CNT_W'(1);
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
`ifdef FB_FILL_PATTERN_INC_EN
            r_data      <= r_data + DATA_W'(1);
`endif
          end
          // An accepted word on the abort edge is already counted above.
          if (abort || (w_accept && w_last)) begin
            r_write <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_write <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address    = r_addr;
  assign bus.writedata  = r_data;
  assign bus.write      = r_write;
  assign bus.chipselect = r_write;
  assign busy           = r_busy;
  assign done           = r_done;
  assign words_written  = r_words;

endmodule

// File: tb/tb_fb_fill_master.sv
// Scoreboard bench for fb_fill_master: directed fills push expected writes
// and completion counts; a negedge monitor pops and compares them.
module tb_fb_fill_master;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [DATA_W-1:0] fill_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_written;

  fb_fill_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_fill_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .fill_data     (fill_data),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t q_wr[$];
  int  q_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] f, input int idx);
`ifdef FB_FILL_PATTERN_INC_EN
    return f + DATA_W'(idx);
`else
    return f + DATA_W'(0 * idx);
`endif
  endfunction

  task automatic push_fill(input int base, input int n, input logic [DATA_W-1:0] d);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.a = ADDR_W'((base + i) % (1 << ADDR_W));
      w.d = exp_data(d, i);
      q_wr.push_back(w);
    end
  endtask

  // Ends #1 into the first cycle after start was sampled (cycle 1).
  task automatic issue_start(input int base, input int cnt, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    base_addr  = ADDR_W'(base);
    word_count = CNT_W'(cnt);
    fill_data  = d;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Counts cycles from k0 until done is seen; returns at that cycle's negedge.
  task automatic wait_done(input int k0, input int exp_k, input string name);
    int k;
    k = k0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (k >= exp_k + 20) begin
        $display("FAIL %s: timeout waiting for done", name);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(k), 64'(exp_k));
  endtask

  // Monitor: accepted writes, completion pulses, and stall stability.
  logic              prev_stall = 1'b0;
  logic              prev_abort = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall && !prev_abort) begin
        check("stall_addr",  64'(bus.address),   64'(prev_addr));
        check("stall_data",  64'(bus.writedata), 64'(prev_data));
        check("stall_write", 64'(bus.write),     64'd1);
      end
      if (bus.write && !bus.waitrequest) begin
        check("cs_eq_write", 64'(bus.chipselect), 64'd1);
        if (q_wr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", bus.address, bus.writedata);
        end else begin
          wr_t w;
          w = q_wr.pop_front();
          check("wr_addr", 64'(bus.address),   64'(w.a));
          check("wr_data", 64'(bus.writedata), 64'(w.d));
        end
      end
      if (done) begin
        if (q_done.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: words_written 0x%0h, no done required", words_written);
        end else begin
          int e;
          e = q_done.pop_front();
          check("done_words", 64'(words_written), 64'(e));
          check("done_busy",  64'(busy), 64'd1);
          check("done_write", 64'(bus.write), 64'd0);
        end
      end
      prev_stall <= bus.write & bus.waitrequest;
      prev_abort <= abort;
      prev_addr  <= bus.address;
      prev_data  <= bus.writedata;
    end else begin
      prev_stall <= 1'b0;
      prev_abort <= 1'b0;
    end
  end

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    base_addr       = '0;
    word_count      = '0;
    fill_data       = '0;
    bus.waitrequest = 1'b0;
    #3;
    check("rst_addr",  64'(bus.address),    64'd0);
    check("rst_data",  64'(bus.writedata),  64'd0);
    check("rst_write", 64'(bus.write),      64'd0);
    check("rst_cs",    64'(bus.chipselect), 64'd0);
    check("rst_busy",  64'(busy),           64'd0);
    check("rst_done",  64'(done),           64'd0);
    check("rst_words", 64'(words_written),  64'd0);
    #20 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Oversized count clamps to a full pass 0x0000..0x7FFF, back-to-back.
    push_fill(0, 32768, 32'hFFFF_FFFF);
    q_done.push_back(32768);
    issue_start(0, 40000, 32'hFFFF_FFFF);
    wait_done(1, 32769, "full_len");
    repeat (3) @(posedge clk);
    #1;
    check("words_hold", 64'(words_written), 64'd32768);
    check("idle_busy",  64'(busy),          64'd0);

    // Address wrap at the top of the space.
    push_fill(32'h7FFE, 4, 32'hA5A5_0001);
    q_done.push_back(4);
    issue_start(32'h7FFE, 4, 32'hA5A5_0001);
    wait_done(1, 5, "wrap_len");

    // Five-cycle stall on word 1.
    push_fill(32'h0100, 3, 32'h1234_5678);
    q_done.push_back(3);
    issue_start(32'h0100, 3, 32'h1234_5678);
    @(posedge clk); #1;
    bus.waitrequest = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.waitrequest = 1'b0;
    wait_done(7, 9, "stall_len");

    // Abort after 100 accepted words; start during WRITE and DONE ignored.
    push_fill(32'h2000, 100, 32'hC0FF_EE00);
    q_done.push_back(100);
    issue_start(32'h2000, 9600, 32'hC0FF_EE00);
    for (int k = 2; k <= 101; k++) begin
      @(posedge clk); #1;
      if (k == 50) begin
        start      = 1'b1;
        base_addr  = 15'h1234;
        word_count = 16'd7;
        fill_data  = 32'h0;
      end
      if (k == 51) start = 1'b0;
      if (k == 101) begin
        bus.waitrequest = 1'b1;
        abort           = 1'b1;
      end
    end
    wait_done(101, 102, "abort_len");
    start = 1'b1;
    word_count = 16'd2;
    @(posedge clk); #1;
    start           = 1'b0;
    abort           = 1'b0;
    bus.waitrequest = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("start_in_done_busy", 64'(busy), 64'd0);

    // Abort on the same edge as an accepted write: that word counts.
    push_fill(32'h0200, 3, 32'h0BAD_F00D);
    q_done.push_back(3);
    issue_start(32'h0200, 5, 32'h0BAD_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    wait_done(3, 4, "abort_accept_len");
    @(posedge clk); #1;
    abort = 1'b0;

    // Zero-length fill: no write, immediate done.
    q_done.push_back(0);
    issue_start(32'h0300, 0, 32'h1111_1111);
    wait_done(1, 1, "zero_len");

    // Pattern wrap case (incrementing only when the macro is defined).
    push_fill(32'h0010, 3, 32'hFFFF_FFFE);
    q_done.push_back(3);
    issue_start(32'h0010, 3, 32'hFFFF_FFFE);
    wait_done(1, 4, "pattern_len");

    // Reset mid-fill: three words land, then everything clears at once.
    push_fill(32'h0400, 3, 32'h5555_AAAA);
    issue_start(32'h0400, 10, 32'h5555_AAAA);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr",  64'(bus.address),    64'd0);
    check("mid_rst_data",  64'(bus.writedata),  64'd0);
    check("mid_rst_write", 64'(bus.write),      64'd0);
    check("mid_rst_cs",    64'(bus.chipselect), 64'd0);
    check("mid_rst_busy",  64'(busy),           64'd0);
    check("mid_rst_done",  64'(done),           64'd0);
    check("mid_rst_words", 64'(words_written),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy",  64'(busy),      64'd0);
    check("post_rst_write", 64'(bus.write), 64'd0);
    repeat (5) @(posedge clk);
    #1;

    check("wr_queue_empty",   64'(q_wr.size()),   64'd0);
    check("done_queue_empty", 64'(q_done.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
